// File: rtl/alu_seq_param.sv
// Parametrised sequential ALU: valid/ready operand intake, one-cycle ops plus
// WIDTH-iteration shift-add multiply and restoring divide. Divider built only with `ALU_DIV_EN`.
module alu_seq_param #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t             r_state;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [SHW-1:0]     r_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_flag_z;
    logic               r_flag_c;
    logic               r_flag_v;
    logic               r_err;
`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   r_b;
`endif

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_shl_ext;
    logic [SHW-1:0]     w_sh;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_res_hi;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic               w_go_exec;
    logic [WIDTH:0]     w_madd;
    logic [WIDTH-1:0]   w_it_acc;
    logic [WIDTH-1:0]   w_it_q;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     w_dshift;
    logic [WIDTH:0]     w_dsub;
    logic               w_dge;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_v    = r_flag_v;
    assign err       = r_err;

    assign w_add     = {1'b0, a} + {1'b0, b};
    assign w_sub     = {1'b0, a} - {1'b0, b};
    assign w_sh      = b[SHW-1:0];
    // Bit WIDTH of the widened shift is the last bit pushed out; 0 when amount is 0.
    assign w_shl_ext = {1'b0, a} << w_sh;

    always_comb begin
        w_res     = '0;
        w_res_hi  = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_err     = 1'b0;
        w_go_exec = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SHL: begin
                w_res = w_shl_ext[WIDTH-1:0];
                w_c   = w_shl_ext[WIDTH];
            end
            OP_SHR: w_res = a >> w_sh;
            OP_SRA: w_res = $unsigned($signed(a) >>> w_sh);
            OP_MUL: w_go_exec = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV: begin
                if (b == '0) begin
                    w_res    = '1;
                    w_res_hi = a;
                    w_err    = 1'b1;
                end else begin
                    w_go_exec = 1'b1;
                end
            end
`endif
            default: w_err = 1'b1;
        endcase
    end

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the {acc, q} pair right by one.
    assign w_madd = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

`ifdef ALU_DIV_EN
    // Restoring step: the sign of the trial subtraction decides the quotient bit.
    assign w_dshift = {r_acc, r_q[WIDTH-1]};
    assign w_dsub   = w_dshift - {1'b0, r_b};
    assign w_dge    = ~w_dsub[WIDTH];
`endif

    always_comb begin
        w_it_acc = r_acc;
        w_it_q   = r_q;
        if (r_op == OP_MUL) begin
            w_it_acc = w_madd[WIDTH:1];
            w_it_q   = {w_madd[0], r_q[WIDTH-1:1]};
        end
`ifdef ALU_DIV_EN
        else if (r_op == OP_DIV) begin
            w_it_acc = w_dge ? w_dsub[WIDTH-1:0] : w_dshift[WIDTH-1:0];
            w_it_q   = {r_q[WIDTH-2:0], w_dge};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_v    <= 1'b0;
            r_err       <= 1'b0;
`ifdef ALU_DIV_EN
            r_b         <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_a   <= a;
                        r_acc <= '0;
                        // MUL walks the multiplier bits, DIV walks the dividend bits.
                        r_q   <= (op == OP_MUL) ? b : a;
`ifdef ALU_DIV_EN
                        r_b   <= b;
`endif
                        if (w_go_exec) begin
                            r_cnt   <= SHW'(WIDTH - 1);
                            r_state <= S_EXEC;
                        end else begin
                            r_result    <= w_res;
                            r_result_hi <= w_res_hi;
                            r_flag_z    <= (w_res == '0) && (w_res_hi == '0);
                            r_flag_c    <= w_c;
                            r_flag_v    <= w_v;
                            r_err       <= w_err;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    r_acc <= w_it_acc;
                    r_q   <= w_it_q;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_result    <= w_it_q;
                        r_result_hi <= w_it_acc;
                        r_flag_z    <= (w_it_q == '0) && (w_it_acc == '0);
                        r_flag_c    <= 1'b0;
                        r_flag_v    <= 1'b0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed self-checking bench for alu_seq_param at WIDTH=16.
module tb_alu_seq_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int l);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic retire(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, out_valid, 0);
        check({tag, "_rdy"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_res", {result_hi, result}, 0);
        check("rst_flags", {flag_z, flag_c, flag_v, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset abandoned mid-multiply
        @(negedge clk);
        op = 4'd8; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mul_busy", in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_vld", out_valid, 0);
        check("rstmid_rdy", in_ready, 1);
        check("rstmid_res", {result_hi, result}, 0);
        check("rstmid_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rstmid_stale", out_valid, 0);

        // ADD wrap to zero with carry
        issue(4'd0, 16'hFFFF, 16'h0001, lat);
        check("add_lat", lat, 1);
        check("add_res", result, 16'h0000);
        check("add_zcv", {flag_z, flag_c, flag_v, err}, 4'b1100);
        retire("add");

        // SUB signed overflow, then backpressure
        issue(4'd1, 16'h8000, 16'h0001, lat);
        check("sub_lat", lat, 1);
        check("sub_res", result, 16'h7FFF);
        check("sub_zcv", {flag_z, flag_c, flag_v, err}, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_vld", out_valid, 1);
            check("bp_rdy", in_ready, 0);
            check("bp_res", {result, flag_v}, {16'h7FFF, 1'b1});
        end
        retire("sub");

        // MUL full product
        issue(4'd8, 16'h1234, 16'h5678, lat);
        check("mul_lat", lat, 17);
        check("mul_prod", {result_hi, result}, 32'h0626_0060);
        check("mul_flags", {flag_z, flag_c, flag_v, err}, 0);
        retire("mul");

`ifdef ALU_DIV_EN
        issue(4'd9, 16'd1000, 16'd7, lat);
        check("div_lat", lat, 17);
        check("div_q", result, 16'd142);
        check("div_r", result_hi, 16'd6);
        check("div_err", err, 0);
        retire("div");
        issue(4'd9, 16'd5, 16'd0, lat);
        check("dz_lat", lat, 1);
        check("dz_res", {result_hi, result}, {16'd5, 16'hFFFF});
        check("dz_err", err, 1);
        retire("dz");
`else
        issue(4'd9, 16'd1000, 16'd7, lat);
        check("divoff_lat", lat, 1);
        check("divoff_res", {result_hi, result}, 0);
        check("divoff_ez", {err, flag_z}, 2'b11);
        retire("divoff");
`endif

        // Illegal opcode
        issue(4'd12, 16'h1234, 16'h4321, lat);
        check("ill_lat", lat, 1);
        check("ill_res", {result_hi, result}, 0);
        check("ill_ez", {err, flag_z}, 2'b11);
        retire("ill");

        // SRA uses only b[3:0] as the amount
        issue(4'd7, 16'h8000, 16'h0013, lat);
        check("sra_res", result, 16'hF000);
        check("sra_cverr", {flag_c, flag_v, err}, 0);
        retire("sra");

        issue(4'd5, 16'h8001, 16'h0001, lat);
        check("shl_res", result, 16'h0002);
        check("shl_c", flag_c, 1);
        retire("shl");

        issue(4'd6, 16'h8001, 16'h0004, lat);
        check("shr_res", result, 16'h0800);
        retire("shr");

        issue(4'd4, 16'hA5A5, 16'h0FF0, lat);
        check("xor_res", result, 16'hAA55);
        check("xor_hi", result_hi, 0);
        retire("xor");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
